sdec_countdown: RTL and testbench
=================================

Name: sdec_countdown

Overview:
- Registered signed down-counter; the decrementing counterpart of the team's signed incrementer component.
- Loads a signed start value and a signed terminal value, then decrements by 1 on each enabled cycle until it reaches the terminal value.
- Signals completion with a one-cycle done pulse.
- Used by the datapath component library wherever a timed countdown or loop bound is needed.

Parameters:
DATAWIDTH, 8, bit width of the start value, the terminal value and the count output (two's complement, signed).

Ports:
Clk  input  1  rising-edge clock
Rst  input  1  asynchronous reset, active-high
start  input  1  load request; sampled on the rising edge of Clk
a  input  DATAWIDTH  signed start value, sampled when start=1
b  input  DATAWIDTH  signed terminal value, sampled when start=1
en  input  1  decrement enable, used only while counting
d  output  DATAWIDTH  signed current count (registered)
busy  output  1  high while counting
done  output  1  one-cycle pulse when the count has reached b
err  output  1  one-cycle pulse when a load request is rejected

Behaviour:
- One clock domain (Clk). Rst is asynchronous and active-high.
- While Rst=1, all of the following hold immediately, independent of Clk:
  - state=IDLE
  - d=0, busy=0, done=0, err=0
  - internal terminal register=0
- Reset asserted mid-count aborts the count; no done pulse follows.
- States: IDLE, COUNT, DONE. All outputs are registered or decoded from the state register:
  - busy = (state==COUNT)
  - done = (state==DONE)
- IDLE or DONE, start=1, signed a >= signed b:
  - d <= a; terminal register <= b; err <= 0; next state COUNT.
- IDLE or DONE, start=1, signed a < signed b:
  - Request is rejected. err=1 for exactly one cycle.
  - d and the terminal register are unchanged; next state IDLE.
- IDLE, start=0: hold d; err=0.
- DONE, start=0: next state IDLE; d is held.
- COUNT, start=1: restart. The same accept/reject rule applies as in IDLE:
  - If accepted, d reloads and the state stays COUNT.
  - If rejected, err pulses and the state goes to IDLE without a done pulse.
- COUNT, start=0, d == terminal: next state DONE, regardless of en. d is held.
- COUNT, start=0, d != terminal, en=1: d <= d - 1.
- COUNT, start=0, d != terminal, en=0: d is held (pause).
- Arithmetic:
  - Subtraction is DATAWIDTH-bit signed.
  - The terminal-value comparison is signed equality; the start check is a signed magnitude compare.
  - Because a >= b is enforced at load, d never passes below the terminal value, so no wrap can occur.
- Latency from the accepting edge k (en held at 1):
  - d=a after edge k.
  - d=b after edge k+(a-b).
  - done=1 after edge k+(a-b)+1, for one cycle.
  - busy=0 from that same edge.
  - a==b gives done one edge after the load.
- en=0 cycles extend the count 1:1.
- done and err are never high in the same cycle.
- d is stable whenever busy=0.
- Back-to-back operation: start asserted in the DONE cycle is accepted, so no idle cycle is required between counts.

Test Plan:
1. Reset/basic count (DATAWIDTH=4):
   - Stimulus: hold Rst, release, then pulse start with a=5, b=2, en=1.
   - Required response: d=0 and all flags 0 during reset; d sequence 5,4,3,2; done=1 exactly one cycle, 4 edges after the load; busy=0 afterwards; d holds at 2.
2. Full-range signed count (DATAWIDTH=4):
   - Stimulus: start with a=7, b=-8.
   - Required response: 15 decrements through 0 into negatives; d=-8 then done; no wrap to +7.
3. Rejection and equal load:
   - Stimulus: start with a=-3, b=1; then start with a=-4, b=-4.
   - Required response: first request gives err=1 for one cycle, busy stays 0, d unchanged; second gives d=-4 and done one edge after the load.
4. Pause:
   - Stimulus: a=3, b=0, with en toggled 1,0,0,1,1.
   - Required response: d=3,2,2,2,1,0 then done; each en=0 cycle holds d.
5. Restart mid-count:
   - Stimulus: start a=6, b=0; at d=4 assert start with a=2, b=1.
   - Required response: d jumps to 2, busy stays 1, then 1, then a single done; no done for the aborted count.
6. Asynchronous reset mid-count and back-to-back loads:
   - Stimulus: pulse Rst asynchronously between edges at d=3.
   - Required response: outputs clear immediately, state IDLE, no done.
   - Stimulus: start asserted in the done cycle with a=1, b=0.
   - Required response: busy=1 on the next edge, then d=0, then done.

Source files
------------

// File: rtl/sdec_countdown_if.sv
// Load/count handshake for the signed down-counter: load request, operands, enable and status.
// The master drives requests; the slave is the counter itself.
interface sdec_countdown_if #(
    parameter int DATAWIDTH = 8
);
    logic                        start;
    logic signed [DATAWIDTH-1:0] a;
    logic signed [DATAWIDTH-1:0] b;
    logic                        en;
    logic signed [DATAWIDTH-1:0] d;
    logic                        busy;
    logic                        done;
    logic                        err;

    modport master (
        output start, a, b, en,
        input  d, busy, done, err
    );

    modport slave (
        input  start, a, b, en,
        output d, busy, done, err
    );
endinterface

// File: rtl/sdec_countdown.sv
// Registered signed down-counter: loads a start and terminal value, decrements on enabled
// cycles, and pulses done one edge after reaching the terminal value.
module sdec_countdown #(
    parameter int DATAWIDTH = 8
) (
    input  logic            Clk,
    input  logic            Rst,
    sdec_countdown_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_COUNT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic signed [DATAWIDTH-1:0] ONE = DATAWIDTH'(1);

    state_t                      r_state;
    logic signed [DATAWIDTH-1:0] r_d;
    logic signed [DATAWIDTH-1:0] r_term;
    logic                        r_err;

    state_t                      w_state_nxt;
    logic signed [DATAWIDTH-1:0] w_d_nxt;
    logic signed [DATAWIDTH-1:0] w_term_nxt;
    logic                        w_err_nxt;
    logic                        w_accept;

    // Loads with a >= b guarantee the count stops at the terminal before any wrap.
    assign w_accept = (bus.a >= bus.b);

    always_comb begin
        // NOTE: every signal gets a default before the branches, so no path leaves one unassigned and no latch is inferred.
        w_state_nxt = r_state;
        w_d_nxt     = r_d;
        w_term_nxt  = r_term;
        w_err_nxt   = 1'b0;

        if (bus.start) begin
            if (w_accept) begin
                w_state_nxt = S_COUNT;
                w_d_nxt     = bus.a;
                w_term_nxt  = bus.b;
            end else begin
                w_state_nxt = S_IDLE;
                w_err_nxt   = 1'b1;
            end
        end else begin
            case (r_state)
                S_IDLE:  w_state_nxt = S_IDLE;
                S_COUNT: begin
                    if (r_d == r_term) begin
                        w_state_nxt = S_DONE;
                    end else if (bus.en) begin
                        w_d_nxt = r_d - ONE;
                    end
                end
                S_DONE:  w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state <= S_IDLE;
            r_d     <= '0;
            r_term  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_d     <= w_d_nxt;
            r_term  <= w_term_nxt;
            r_err   <= w_err_nxt;
        end
    end

    assign bus.d    = r_d;
    assign bus.busy = (r_state == S_COUNT);
    assign bus.done = (r_state == S_DONE);
    assign bus.err  = r_err;
endmodule

// File: tb/tb_sdec_countdown.sv
// Bench for sdec_countdown: directed scenarios with literal expectations, then random
// traffic, all cross-checked every cycle against an integer reference model.
module tb_sdec_countdown;
    localparam int W = 4;

    logic Clk;
    logic Rst;
    int   n_total = 0;
    int   n_bad   = 0;

    sdec_countdown_if #(.DATAWIDTH(W)) bus ();

    sdec_countdown #(.DATAWIDTH(W)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference model: the counter's meaning as integers -- current value, goal, and
    // whether we are counting, just finished, or just rejected a request.
    int m_val      = 0;
    int m_goal     = 0;
    bit m_counting = 0;
    bit m_finished = 0;
    bit m_rejected = 0;

    always @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            m_val = 0; m_goal = 0;
            m_counting = 0; m_finished = 0; m_rejected = 0;
        end else begin
            automatic int sa = int'(bus.a);
            automatic int sb = int'(bus.b);
            m_finished = 0;
            m_rejected = 0;
            if (bus.start) begin
                if (sa >= sb) begin
                    m_val = sa; m_goal = sb; m_counting = 1;
                end else begin
                    m_rejected = 1; m_counting = 0;
                end
            end else if (m_counting) begin
                if (m_val == m_goal) begin
                    m_counting = 0; m_finished = 1;
                end else if (bus.en) begin
                    m_val = m_val - 1;
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge Clk) begin
        check("model_d",    int'(bus.d),    m_val);
        check("model_busy", int'(bus.busy), int'(m_counting));
        check("model_done", int'(bus.done), int'(m_finished));
        check("model_err",  int'(bus.err),  int'(m_rejected));
        check("done_err_exclusive", int'(bus.done && bus.err), 0);
    end

    // Drive inputs for the next rising edge, then return at the following falling edge.
    task automatic cyc(input logic s, input int av, input int bv, input logic e);
        bus.start = s;
        bus.a     = av[W-1:0];
        bus.b     = bv[W-1:0];
        bus.en    = e;
        @(negedge Clk);
    endtask

    task automatic expect_out(input string name, input int d, input int busy, input int done, input int err);
        check({name, "_d"},    int'(bus.d),    d);
        check({name, "_busy"}, int'(bus.busy), busy);
        check({name, "_done"}, int'(bus.done), done);
        check({name, "_err"},  int'(bus.err),  err);
    endtask

    // Pulse reset between edges and confirm the outputs clear without waiting for a clock.
    task automatic async_reset_pulse();
        #2 Rst = 1'b1;
        #1 expect_out("async_rst", 0, 0, 0, 0);
        #1 Rst = 1'b0;
    endtask

    initial begin
        Rst = 1'b1;
        bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.en = 1'b0;
        #3 expect_out("in_reset", 0, 0, 0, 0);
        @(negedge Clk);
        @(negedge Clk);
        Rst = 1'b0;

        // Basic count 5 -> 2
        cyc(1, 5, 2, 1);  expect_out("t1_load", 5, 1, 0, 0);
        cyc(0, 0, 0, 1);  expect_out("t1_c4", 4, 1, 0, 0);
        cyc(0, 0, 0, 1);  expect_out("t1_c3", 3, 1, 0, 0);
        cyc(0, 0, 0, 1);  expect_out("t1_c2", 2, 1, 0, 0);
        cyc(0, 0, 0, 1);  expect_out("t1_done", 2, 0, 1, 0);
        cyc(0, 0, 0, 1);  expect_out("t1_hold", 2, 0, 0, 0);

        // Full signed range 7 -> -8
        cyc(1, 7, -8, 1); expect_out("t2_load", 7, 1, 0, 0);
        for (int i = 1; i <= 15; i++) begin
            cyc(0, 0, 0, 1);
            check("t2_step", int'(bus.d), 7 - i);
        end
        cyc(0, 0, 0, 1);  expect_out("t2_done", -8, 0, 1, 0);
        cyc(0, 0, 0, 1);  expect_out("t2_idle", -8, 0, 0, 0);

        // Rejection, then equal load
        cyc(1, -3, 1, 1); expect_out("t3_reject", -8, 0, 0, 1);
        cyc(0, 0, 0, 1);  expect_out("t3_after", -8, 0, 0, 0);
        cyc(1, -4, -4, 1); expect_out("t3_eq_load", -4, 1, 0, 0);
        cyc(0, 0, 0, 1);  expect_out("t3_eq_done", -4, 0, 1, 0);
        cyc(0, 0, 0, 0);

        // Pause with en = 1,0,0,1,1
        cyc(1, 3, 0, 1);  expect_out("t4_load", 3, 1, 0, 0);
        cyc(0, 0, 0, 1);  check("t4_e1", int'(bus.d), 2);
        cyc(0, 0, 0, 0);  check("t4_e0a", int'(bus.d), 2);
        cyc(0, 0, 0, 0);  check("t4_e0b", int'(bus.d), 2);
        cyc(0, 0, 0, 1);  check("t4_e1b", int'(bus.d), 1);
        cyc(0, 0, 0, 1);  expect_out("t4_zero", 0, 1, 0, 0);
        cyc(0, 0, 0, 0);  expect_out("t4_done", 0, 0, 1, 0);
        cyc(0, 0, 0, 0);

        // Restart mid-count
        cyc(1, 6, 0, 1);  expect_out("t5_load", 6, 1, 0, 0);
        cyc(0, 0, 0, 1);  check("t5_c5", int'(bus.d), 5);
        cyc(0, 0, 0, 1);  check("t5_c4", int'(bus.d), 4);
        cyc(1, 2, 1, 1);  expect_out("t5_reload", 2, 1, 0, 0);
        cyc(0, 0, 0, 1);  expect_out("t5_c1", 1, 1, 0, 0);
        cyc(0, 0, 0, 1);  expect_out("t5_done", 1, 0, 1, 0);
        cyc(0, 0, 0, 1);  expect_out("t5_idle", 1, 0, 0, 0);

        // Async reset at d=3, then back-to-back loads
        cyc(1, 5, 0, 1);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);  check("t6_pre_rst", int'(bus.d), 3);
        async_reset_pulse();
        cyc(0, 0, 0, 1);  expect_out("t6_post_rst", 0, 0, 0, 0);
        cyc(1, 3, 1, 1);  expect_out("t6_load", 3, 1, 0, 0);
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);  check("t6_c1", int'(bus.d), 1);
        cyc(0, 0, 0, 1);  expect_out("t6_done", 1, 0, 1, 0);
        cyc(1, 1, 0, 1);  expect_out("t6_b2b_load", 1, 1, 0, 0);
        cyc(0, 0, 0, 1);  expect_out("t6_b2b_c0", 0, 1, 0, 0);
        cyc(0, 0, 0, 1);  expect_out("t6_b2b_done", 0, 0, 1, 0);

        // Random traffic, checked by the model on every falling edge
        for (int i = 0; i < 600; i++) begin
            automatic logic s  = ($urandom_range(0, 5) == 0);
            automatic int   av = int'($urandom_range(0, 15)) - 8;
            automatic int   bv = int'($urandom_range(0, 15)) - 8;
            automatic logic e  = ($urandom_range(0, 3) != 0);
            cyc(s, av, bv, e);
            if ($urandom_range(0, 79) == 0) async_reset_pulse();
        end
        cyc(0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
